vec_csr_state_collector: RTL and testbench

VEC_CSR_STATE_COLLECTOR -- requirements
Module: vec_csr_state_collector

---
 rtl/vec_csr_state_collector_pkg.sv | 20 ++
 rtl/vec_csr_state_collector.sv | 124 ++++++++++++
 tb/tb_vec_csr_state_collector.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vec_csr_state_collector_pkg.sv
// Shared difftest constants for the vector CSR state collector.
// Holds the CSR addresses, the illegal-vtype reset value and the vcsr packing helper.
package vec_csr_state_collector_pkg;

  localparam logic [11:0] CSR_VSTART = 12'h008;
  localparam logic [11:0] CSR_VXSAT  = 12'h009;
  localparam logic [11:0] CSR_VXRM   = 12'h00A;
  localparam logic [11:0] CSR_VCSR   = 12'h00F;
  localparam logic [11:0] CSR_VL     = 12'hC20;
  localparam logic [11:0] CSR_VTYPE  = 12'hC21;
  localparam logic [11:0] CSR_VLENB  = 12'hC22;

  localparam logic [63:0] VTYPE_VILL = 64'h8000_0000_0000_0000;

  // vcsr is the read-only alias {vxrm, vxsat}, zero-extended to 64 bits
  function automatic logic [63:0] packVcsr(input logic [1:0] vxrm, input logic vxsat);
    return {61'b0, vxrm, vxsat};
  endfunction

endpackage

// File: rtl/vec_csr_state_collector.sv
// Shadows the architectural vector CSRs and emits a one-cycle difftest snapshot
// whenever any of them changes, on a forced request, or once after reset.
module vec_csr_state_collector
  import vec_csr_state_collector_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_csr_wen,
  input  logic [11:0] io_csr_waddr,
  input  logic [63:0] io_csr_wdata,
  input  logic        io_vset_valid,
  input  logic [63:0] io_vset_vl,
  input  logic [63:0] io_vset_vtype,
  input  logic        io_vset_vill,
  input  logic        io_vxsat_set,
  input  logic        io_vinst_commit,
  input  logic        io_force,
  input  logic [7:0]  io_coreid,
  output logic        diff_enable,
  output logic [63:0] diff_vstart,
  output logic [63:0] diff_vxsat,
  output logic [63:0] diff_vxrm,
  output logic [63:0] diff_vcsr,
  output logic [63:0] diff_vl,
  output logic [63:0] diff_vtype,
  output logic [63:0] diff_vlenb,
  output logic [7:0]  diff_coreid
);

  localparam int VSW = $clog2(VLEN);
  localparam logic [63:0] VLENB_VALUE = 64'(VLEN / 8);

  logic [VSW-1:0] r_vstart;
  logic           r_vxsat;
  logic [1:0]     r_vxrm;
  logic [63:0]    r_vl;
  logic [63:0]    r_vtype;
  logic           r_pending;

  logic [VSW-1:0] w_vstartNext;
  logic           w_vxsatNext;
  logic [1:0]     w_vxrmNext;
  logic [63:0]    w_vlNext;
  logic [63:0]    w_vtypeNext;
  logic           w_change;

  // Later assignments take priority, so explicit CSR writes beat the implicit updates
  always_comb begin
    w_vstartNext = r_vstart;
    w_vxsatNext  = r_vxsat;
    w_vxrmNext   = r_vxrm;
    w_vlNext     = r_vl;
    w_vtypeNext  = r_vtype;

    if (io_vinst_commit) w_vstartNext = '0;
    if (io_vxsat_set)    w_vxsatNext  = 1'b1;

    if (io_csr_wen) begin
      unique case (io_csr_waddr)
        CSR_VSTART: w_vstartNext = io_csr_wdata[VSW-1:0];
        CSR_VXSAT:  w_vxsatNext  = io_csr_wdata[0];
        CSR_VXRM:   w_vxrmNext   = io_csr_wdata[1:0];
        CSR_VCSR: begin
          w_vxsatNext = io_csr_wdata[0];
          w_vxrmNext  = io_csr_wdata[2:1];
        end
        default: ;
      endcase
    end

    if (io_vset_valid) begin
      if (io_vset_vill) begin
        w_vlNext    = '0;
        w_vtypeNext = VTYPE_VILL;
      end else begin
        w_vlNext    = io_vset_vl;
        w_vtypeNext = io_vset_vtype;
      end
    end
  end

  assign w_change = (w_vstartNext != r_vstart) || (w_vxsatNext != r_vxsat) ||
                    (w_vxrmNext != r_vxrm) || (w_vlNext != r_vl) ||
                    (w_vtypeNext != r_vtype) || io_force || r_pending;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_vstart    <= '0;
      r_vxsat     <= 1'b0;
      r_vxrm      <= 2'b0;
      r_vl        <= '0;
      r_vtype     <= VTYPE_VILL;
      r_pending   <= 1'b1;
      diff_enable <= 1'b0;
      diff_vstart <= '0;
      diff_vxsat  <= '0;
      diff_vxrm   <= '0;
      diff_vcsr   <= '0;
      diff_vl     <= '0;
      diff_vtype  <= '0;
      diff_vlenb  <= '0;
      diff_coreid <= '0;
    end else begin
      r_vstart    <= w_vstartNext;
      r_vxsat     <= w_vxsatNext;
      r_vxrm      <= w_vxrmNext;
      r_vl        <= w_vlNext;
      r_vtype     <= w_vtypeNext;
      r_pending   <= 1'b0;
      diff_enable <= w_change;
      diff_vstart <= {{(64-VSW){1'b0}}, w_vstartNext};
      diff_vxsat  <= {63'b0, w_vxsatNext};
      diff_vxrm   <= {62'b0, w_vxrmNext};
      diff_vcsr   <= packVcsr(w_vxrmNext, w_vxsatNext);
      diff_vl     <= w_vlNext;
      diff_vtype  <= w_vtypeNext;
      diff_vlenb  <= VLENB_VALUE;
      diff_coreid <= io_coreid;
    end
  end

endmodule

// File: tb/tb_vec_csr_state_collector.sv
// Directed bench for vec_csr_state_collector: a table of single-cycle vectors
// plus hand-written sequences around reset release and mid-stream reset.
module tb_vec_csr_state_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_csr_wen;
  logic [11:0] io_csr_waddr;
  logic [63:0] io_csr_wdata;
  logic        io_vset_valid;
  logic [63:0] io_vset_vl;
  logic [63:0] io_vset_vtype;
  logic        io_vset_vill;
  logic        io_vxsat_set;
  logic        io_vinst_commit;
  logic        io_force;
  logic [7:0]  io_coreid;
  logic        diff_enable;
  logic [63:0] diff_vstart, diff_vxsat, diff_vxrm, diff_vcsr;
  logic [63:0] diff_vl, diff_vtype, diff_vlenb;
  logic [7:0]  diff_coreid;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [63:0] VILL = 64'h8000_0000_0000_0000;

  vec_csr_state_collector #(.VLEN(128)) dut (
    .clock(clock), .reset(reset),
    .io_csr_wen(io_csr_wen), .io_csr_waddr(io_csr_waddr), .io_csr_wdata(io_csr_wdata),
    .io_vset_valid(io_vset_valid), .io_vset_vl(io_vset_vl), .io_vset_vtype(io_vset_vtype),
    .io_vset_vill(io_vset_vill), .io_vxsat_set(io_vxsat_set),
    .io_vinst_commit(io_vinst_commit), .io_force(io_force), .io_coreid(io_coreid),
    .diff_enable(diff_enable), .diff_vstart(diff_vstart), .diff_vxsat(diff_vxsat),
    .diff_vxrm(diff_vxrm), .diff_vcsr(diff_vcsr), .diff_vl(diff_vl),
    .diff_vtype(diff_vtype), .diff_vlenb(diff_vlenb), .diff_coreid(diff_coreid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        vsetValid;
    logic [63:0] vsetVl;
    logic [63:0] vsetVtype;
    logic        vill;
    logic        vxsatSet;
    logic        commit;
    logic        forceSnap;
    logic [7:0]  coreid;
    logic        expEnable;
    logic [63:0] expVstart;
    logic        expVxsat;
    logic [1:0]  expVxrm;
    logic [63:0] expVl;
    logic [63:0] expVtype;
  } vector_t;

  vector_t vectors[16];

  task automatic applyStimulus(input vector_t v);
    io_csr_wen      = v.wen;
    io_csr_waddr    = v.waddr;
    io_csr_wdata    = v.wdata;
    io_vset_valid   = v.vsetValid;
    io_vset_vl      = v.vsetVl;
    io_vset_vtype   = v.vsetVtype;
    io_vset_vill    = v.vill;
    io_vxsat_set    = v.vxsatSet;
    io_vinst_commit = v.commit;
    io_force        = v.forceSnap;
    io_coreid       = v.coreid;
  endtask

  // Advance one clock and settle just after the edge before sampling
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkSnapshot(input string tag, input logic en, input logic [63:0] vstart,
                               input logic vxsat, input logic [1:0] vxrm, input logic [63:0] vl,
                               input logic [63:0] vtype, input logic [63:0] vlenb,
                               input logic [7:0] coreid);
    checkOutput({tag, ".enable"}, {63'b0, diff_enable}, {63'b0, en});
    checkOutput({tag, ".vstart"}, diff_vstart, vstart);
    checkOutput({tag, ".vxsat"},  diff_vxsat,  {63'b0, vxsat});
    checkOutput({tag, ".vxrm"},   diff_vxrm,   {62'b0, vxrm});
    checkOutput({tag, ".vcsr"},   diff_vcsr,   {61'b0, vxrm, vxsat});
    checkOutput({tag, ".vl"},     diff_vl,     vl);
    checkOutput({tag, ".vtype"},  diff_vtype,  vtype);
    checkOutput({tag, ".vlenb"},  diff_vlenb,  vlenb);
    checkOutput({tag, ".coreid"}, {56'b0, diff_coreid}, {56'b0, coreid});
  endtask

  function automatic vector_t mk(input logic wen, input logic [11:0] waddr, input logic [63:0] wdata,
                                 input logic vs, input logic [63:0] vl, input logic [63:0] vt,
                                 input logic vill, input logic vxs, input logic cm, input logic fc,
                                 input logic [7:0] cid, input logic en, input logic [63:0] eVstart,
                                 input logic eVxsat, input logic [1:0] eVxrm, input logic [63:0] eVl,
                                 input logic [63:0] eVtype);
    vector_t v;
    v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    v.vsetValid = vs; v.vsetVl = vl; v.vsetVtype = vt; v.vill = vill;
    v.vxsatSet = vxs; v.commit = cm; v.forceSnap = fc; v.coreid = cid;
    v.expEnable = en; v.expVstart = eVstart; v.expVxsat = eVxsat; v.expVxrm = eVxrm;
    v.expVl = eVl; v.expVtype = eVtype;
    return v;
  endfunction

  vector_t idle;

  initial begin
    idle = mk(0, 12'h0, 64'h0, 0, 64'h0, 64'h0, 0, 0, 0, 0, 8'h5A, 0, 0, 0, 0, 0, 0);

    //               wen addr    wdata     vs vl     vtype   vill vxs cm fc cid    en vstart vxsat vxrm vl vtype
    vectors[0]  = mk(1, 12'h00F, 64'h5,    0, 64'h0, 64'h0,  0,   0,  0, 0, 8'h5A, 1, 0,     1,    2,   0, VILL);
    vectors[1]  = mk(1, 12'h00F, 64'h5,    0, 64'h0, 64'h0,  0,   0,  0, 0, 8'h5A, 0, 0,     1,    2,   0, VILL);
    vectors[2]  = mk(0, 12'h000, 64'h0,    1, 64'h8, 64'h18, 0,   0,  0, 0, 8'h5A, 1, 0,     1,    2,   8, 64'h18);
    vectors[3]  = mk(0, 12'h000, 64'h0,    1, 64'h21,64'h7,  1,   0,  0, 0, 8'h5A, 1, 0,     1,    2,   0, VILL);
    vectors[4]  = mk(1, 12'h008, 64'h5,    0, 64'h0, 64'h0,  0,   0,  1, 0, 8'h5A, 1, 5,     1,    2,   0, VILL);
    vectors[5]  = mk(1, 12'h009, 64'h0,    0, 64'h0, 64'h0,  0,   1,  0, 0, 8'h5A, 1, 5,     0,    2,   0, VILL);
    vectors[6]  = mk(0, 12'h000, 64'h0,    0, 64'h0, 64'h0,  0,   1,  0, 0, 8'h5A, 1, 5,     1,    2,   0, VILL);
    vectors[7]  = mk(0, 12'h000, 64'h0,    0, 64'h0, 64'h0,  0,   1,  0, 0, 8'h5A, 0, 5,     1,    2,   0, VILL);
    vectors[8]  = mk(0, 12'h000, 64'h0,    0, 64'h0, 64'h0,  0,   0,  1, 0, 8'h5A, 1, 0,     1,    2,   0, VILL);
    vectors[9]  = mk(1, 12'hC22, 64'hFF,   0, 64'h0, 64'h0,  0,   0,  0, 0, 8'h5A, 0, 0,     1,    2,   0, VILL);
    vectors[10] = mk(1, 12'hC20, 64'h3,    0, 64'h0, 64'h0,  0,   0,  0, 0, 8'h5A, 0, 0,     1,    2,   0, VILL);
    vectors[11] = mk(0, 12'h000, 64'h0,    0, 64'h0, 64'h0,  0,   0,  0, 1, 8'h3C, 1, 0,     1,    2,   0, VILL);
    vectors[12] = mk(1, 12'h00A, 64'h3,    1, 64'h4, 64'h10, 0,   0,  0, 0, 8'h5A, 1, 0,     1,    3,   4, 64'h10);
    vectors[13] = mk(1, 12'h008, 64'h1FF,  0, 64'h0, 64'h0,  0,   0,  0, 0, 8'h5A, 1, 64'h7F,1,    3,   4, 64'h10);
    vectors[14] = mk(1, 12'h00F, 64'h0,    0, 64'h0, 64'h0,  0,   0,  0, 0, 8'h5A, 1, 64'h7F,0,    0,   4, 64'h10);
    vectors[15] = mk(0, 12'h000, 64'h0,    0, 64'h0, 64'h0,  0,   0,  0, 0, 8'h77, 0, 64'h7F,0,    0,   4, 64'h10);

    // Reset held with inputs idle: every output sits at zero
    reset = 1'b0;
    applyStimulus(idle);
    repeat (3) tick();
    checkSnapshot("reset", 0, 0, 0, 0, 0, 0, 0, 8'h00);

    // First cycle after release carries the reset-state snapshot, then silence
    reset = 1'b1;
    tick();
    checkSnapshot("release", 1, 0, 0, 0, 0, VILL, 64'd16, 8'h5A);
    tick();
    checkOutput("release.quiet1", {63'b0, diff_enable}, 64'h0);
    tick();
    checkOutput("release.quiet2", {63'b0, diff_enable}, 64'h0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vectors[i]);
      tick();
      checkSnapshot($sformatf("vec%0d", i), vectors[i].expEnable, vectors[i].expVstart,
                    vectors[i].expVxsat, vectors[i].expVxrm, vectors[i].expVl,
                    vectors[i].expVtype, 64'd16, vectors[i].coreid);
    end

    // Back-to-back changes give back-to-back pulses
    applyStimulus(mk(1, 12'h009, 64'h1, 0, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput("b2b.first", {63'b0, diff_enable}, 64'h1);
    applyStimulus(mk(1, 12'h009, 64'h0, 0, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput("b2b.second", {63'b0, diff_enable}, 64'h1);
    checkOutput("b2b.vxsat", diff_vxsat, 64'h0);

    // vstart write, then reset the next cycle together with a competing write
    applyStimulus(mk(1, 12'h008, 64'h3, 0, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput("midrst.write", diff_vstart, 64'h3);
    reset = 1'b0;
    applyStimulus(mk(1, 12'h009, 64'h1, 1, 64'h9, 64'h9, 0, 1, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 0));
    tick();
    checkSnapshot("midrst", 0, 0, 0, 0, 0, 0, 0, 8'h00);
    applyStimulus(idle);
    tick();
    checkSnapshot("midrst.hold", 0, 0, 0, 0, 0, 0, 0, 8'h00);
    reset = 1'b1;
    tick();
    checkSnapshot("rerelease", 1, 0, 0, 0, 0, VILL, 64'd16, 8'h5A);
    tick();
    checkOutput("rerelease.quiet", {63'b0, diff_enable}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
